// File: rtl/ycr1_imem_router_mp_pkg.sv
// Purpose: shared memory-interface encodings and default widths for the imem router.
// Contents: imem address/data width defaults, cmd/resp encodings, tag-width helper.
package ycr1_imem_router_mp_pkg;

   localparam int unsigned YCR1_IMEM_AWIDTH = 32;
   localparam int unsigned YCR1_IMEM_DWIDTH = 32;

   typedef enum logic {
      YCR1_MEM_CMD_RD = 1'b0,
      YCR1_MEM_CMD_WR = 1'b1
   } type_ycr1_mem_cmd_e;

   typedef enum logic [1:0] {
      YCR1_MEM_RESP_NOTRDY = 2'b00,
      YCR1_MEM_RESP_RDY_OK = 2'b01,
      YCR1_MEM_RESP_RDY_ER = 2'b10
   } type_ycr1_mem_resp_e;

   // Tag must encode every port index plus one extra value for a decode miss.
   function automatic int unsigned tag_width(input int unsigned port_cnt);
      return $clog2(port_cnt + 1);
   endfunction

endpackage

// File: rtl/ycr1_imem_rt_tagfifo.sv
// Purpose: small synchronous FIFO holding the target tag of every accepted,
//          not-yet-answered fetch. Head is read combinationally.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   push, din    enqueue a tag (honoured when not full, or full with same-cycle pop)
//   pop          dequeue head (ignored when empty)
//   head         oldest tag
//   full, empty  status
//   count        current occupancy
module ycr1_imem_rt_tagfifo #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // At full, the slot being popped this cycle is the one written.
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   // Storage and pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ycr1_imem_router_mp.sv
// Purpose: N-port instruction-memory router. Decodes the core fetch address,
//          forwards the request to one target port and returns responses in
//          order using a tag FIFO of outstanding fetches. Decode misses (when
//          no default port) are answered internally with RDY_ER.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   imem_req/_req_ack/_cmd/_addr   core request side
//   imem_rdata/imem_resp           core response side
//   port_req/_req_ack/_cmd/_addr   per-target request side (cmd/addr broadcast)
//   port_rdata/port_resp           per-target response side
module ycr1_imem_router_mp
   import ycr1_imem_router_mp_pkg::*;
#(
   parameter int unsigned                    PORT_CNT          = 4,
   parameter int unsigned                    AWIDTH            = YCR1_IMEM_AWIDTH,
   parameter int unsigned                    DWIDTH            = YCR1_IMEM_DWIDTH,
   parameter int unsigned                    OUTSTD_DEPTH      = 2,
   parameter logic [PORT_CNT*AWIDTH-1:0]     PORT_ADDR_MASK    = {PORT_CNT{AWIDTH'(32'hFFFF_0000)}},
   parameter logic [PORT_CNT*AWIDTH-1:0]     PORT_ADDR_PATTERN = (PORT_CNT*AWIDTH)'(
      {32'h0007_0000, 32'h0006_0000, 32'h0005_0000, 32'h0004_0000,
       32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000}),
   parameter bit                             DFLT_PORT_EN      = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         imem_req,
   output logic                         imem_req_ack,
   input  logic                         imem_cmd,
   input  logic [AWIDTH-1:0]            imem_addr,
   output logic [DWIDTH-1:0]            imem_rdata,
   output logic [1:0]                   imem_resp,
   output logic [PORT_CNT-1:0]          port_req,
   input  logic [PORT_CNT-1:0]          port_req_ack,
   output logic [PORT_CNT-1:0]          port_cmd,
   output logic [PORT_CNT*AWIDTH-1:0]   port_addr,
   input  logic [PORT_CNT*DWIDTH-1:0]   port_rdata,
   input  logic [PORT_CNT*2-1:0]        port_resp
);

   localparam int unsigned TW       = tag_width(PORT_CNT);
   localparam int unsigned CW       = $clog2(OUTSTD_DEPTH + 1);
   localparam logic [TW-1:0] TAG_MISS = TW'(PORT_CNT);

   logic [TW-1:0]     sel;
   logic [TW-1:0]     last_tag;
   logic [TW-1:0]     head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic              full_eff;
   logic              empty_eff;
   logic              can_issue;
   logic              ack_sel;
   logic              push;
   logic              pop;
   logic              head_miss;
   logic [1:0]        resp_sel;
   logic [DWIDTH-1:0] rdata_sel;

   // Address decode: lowest matching port wins
   always_comb begin
      sel = DFLT_PORT_EN ? '0 : TAG_MISS;
      for (int i = int'(PORT_CNT) - 1; i >= 0; i--) begin
         if ((imem_addr & PORT_ADDR_MASK[i*AWIDTH +: AWIDTH]) == PORT_ADDR_PATTERN[i*AWIDTH +: AWIDTH])
            sel = TW'(i);
      end
   end

   // Response mux indexed by the head tag
   always_comb begin
      resp_sel  = YCR1_MEM_RESP_NOTRDY;
      rdata_sel = '0;
      for (int i = 0; i < int'(PORT_CNT); i++) begin
         if (head == TW'(i)) begin
            resp_sel  = port_resp[i*2 +: 2];
            rdata_sel = port_rdata[i*DWIDTH +: DWIDTH];
         end
      end
   end

   assign head_miss = (head == TAG_MISS);
   // A miss at the head answers as soon as it gets there; port heads wait for their resp.
   assign pop       = ~fifo_empty & (head_miss | (resp_sel != YCR1_MEM_RESP_NOTRDY));

   // Issue gate: same-cycle pop frees a slot, and lets a new target start once
   // the last outstanding fetch drains. Switching targets with others in flight
   // is blocked so responses cannot overtake each other.
   assign full_eff  = fifo_full & ~pop;
   assign empty_eff = fifo_empty | ((fifo_count == CW'(1)) & pop);
   assign can_issue = rst_n & imem_req & ~full_eff & (empty_eff | (sel == last_tag));

   always_comb begin
      port_req = '0;
      ack_sel  = 1'b0;
      for (int i = 0; i < int'(PORT_CNT); i++) begin
         if (sel == TW'(i)) begin
            port_req[i] = can_issue;
            ack_sel     = port_req_ack[i];
         end
      end
   end

   assign imem_req_ack = can_issue & ((sel == TAG_MISS) | ack_sel);
   assign push         = imem_req_ack;

   assign port_cmd  = {PORT_CNT{imem_cmd}};
   assign port_addr = {PORT_CNT{imem_addr}};

   // Core-facing response
   always_comb begin
      imem_resp  = YCR1_MEM_RESP_NOTRDY;
      imem_rdata = '0;
      if (!fifo_empty) begin
         if (head_miss) begin
            imem_resp = YCR1_MEM_RESP_RDY_ER;
         end else begin
            imem_resp = resp_sel;
            if (resp_sel != YCR1_MEM_RESP_NOTRDY) imem_rdata = rdata_sel;
         end
      end
   end

   // Target of the most recent accepted fetch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    last_tag <= '0;
      else if (push) last_tag <= sel;
   end

   ycr1_imem_rt_tagfifo #(
      .WIDTH (TW),
      .DEPTH (OUTSTD_DEPTH)
   ) u_tagfifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (sel),
      .pop   (pop),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

`ifdef YCR1_TRGT_SIMULATION
   logic [PORT_CNT*2-1:0] head_resp_mask;
   always_comb begin
      head_resp_mask = '0;
      for (int i = 0; i < int'(PORT_CNT); i++)
         if (!fifo_empty && head == TW'(i)) head_resp_mask[i*2 +: 2] = 2'b11;
   end

   a_no_x_req: assert property (@(posedge clk) disable iff (!rst_n)
      imem_req |-> !$isunknown({imem_cmd, imem_addr}));
   a_no_resp_empty: assert property (@(posedge clk) disable iff (!rst_n)
      fifo_empty |-> (port_resp == '0));
   a_no_spurious: assert property (@(posedge clk) disable iff (!rst_n)
      (port_resp & ~head_resp_mask) == '0);
   a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
      fifo_count <= CW'(OUTSTD_DEPTH));
`endif

endmodule

// File: tb/tb_ycr1_imem_router_mp.sv
// Purpose: directed self-checking bench for ycr1_imem_router_mp (4 ports,
//          2 outstanding, no default port so misses answer RDY_ER).
module tb_ycr1_imem_router_mp;

   localparam int unsigned PC = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   localparam logic [1:0] NOTRDY = 2'b00;
   localparam logic [1:0] RDY_OK = 2'b01;
   localparam logic [1:0] RDY_ER = 2'b10;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              imem_req;
   logic              imem_req_ack;
   logic              imem_cmd;
   logic [AW-1:0]     imem_addr;
   logic [DW-1:0]     imem_rdata;
   logic [1:0]        imem_resp;
   logic [PC-1:0]     port_req;
   logic [PC-1:0]     port_req_ack;
   logic [PC-1:0]     port_cmd;
   logic [PC*AW-1:0]  port_addr;
   logic [PC*DW-1:0]  port_rdata;
   logic [PC*2-1:0]   port_resp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ycr1_imem_router_mp #(
      .PORT_CNT          (PC),
      .AWIDTH            (AW),
      .DWIDTH            (DW),
      .OUTSTD_DEPTH      (2),
      .PORT_ADDR_MASK    ({PC{32'hFFFF_0000}}),
      .PORT_ADDR_PATTERN ({32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000}),
      .DFLT_PORT_EN      (1'b0)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req     (imem_req),
      .imem_req_ack (imem_req_ack),
      .imem_cmd     (imem_cmd),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .imem_resp    (imem_resp),
      .port_req     (port_req),
      .port_req_ack (port_req_ack),
      .port_cmd     (port_cmd),
      .port_addr    (port_addr),
      .port_rdata   (port_rdata),
      .port_resp    (port_resp)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid_cyc();
      @(negedge clk);
   endtask

   task automatic ports_idle();
      port_resp  = '0;
      port_rdata = '0;
   endtask

   task automatic drive_resp(input int p, input logic [1:0] r, input logic [31:0] d);
      port_resp  = '0;
      port_rdata = '0;
      port_resp[p*2 +: 2]   = r;
      port_rdata[p*DW +: DW] = d;
   endtask

   task automatic fetch(input logic [31:0] a);
      imem_req  = 1'b1;
      imem_addr = a;
   endtask

   task automatic no_fetch();
      imem_req  = 1'b0;
      imem_addr = '0;
   endtask

   initial begin
      rst_n        = 1'b0;
      imem_cmd     = 1'b0;
      port_req_ack = '1;
      no_fetch();
      ports_idle();
      #3;
      check("rst_ack",   32'(imem_req_ack), 32'h0);
      check("rst_resp",  32'(imem_resp),    32'(NOTRDY));
      check("rst_rdata", imem_rdata,        32'h0);
      check("rst_preq",  32'(port_req),     32'h0);
      #9 rst_n = 1'b1;

      // 1: single fetch to port1
      next_cyc(); fetch(32'h0001_0004);
      mid_cyc();
      check("t1_preq",  32'(port_req),     32'h2);
      check("t1_ack",   32'(imem_req_ack), 32'h1);
      check("t1_paddr", port_addr[1*AW +: AW], 32'h0001_0004);
      check("t1_resp0", 32'(imem_resp),    32'(NOTRDY));
      next_cyc(); no_fetch(); drive_resp(1, RDY_OK, 32'hDEAD_BEEF);
      mid_cyc();
      check("t1_resp",  32'(imem_resp), 32'(RDY_OK));
      check("t1_rdata", imem_rdata,     32'hDEAD_BEEF);
      next_cyc(); ports_idle();
      mid_cyc();
      check("t1_idle",  32'(imem_resp), 32'(NOTRDY));

      // 2: three fetches to port2, depth 2, port2 answers 3 cycles after first accept
      next_cyc(); fetch(32'h0002_0000);
      mid_cyc(); check("t2_ack0", 32'(imem_req_ack), 32'h1);
      next_cyc(); fetch(32'h0002_0004);
      mid_cyc(); check("t2_ack1", 32'(imem_req_ack), 32'h1);
      next_cyc(); fetch(32'h0002_0008);
      mid_cyc();
      check("t2_ack2_held",  32'(imem_req_ack), 32'h0);
      check("t2_preq_held",  32'(port_req),     32'h0);
      next_cyc(); drive_resp(2, RDY_OK, 32'h2000_0000);
      mid_cyc();
      check("t2_ack2",   32'(imem_req_ack), 32'h1);
      check("t2_preq2",  32'(port_req),     32'h4);
      check("t2_rdata0", imem_rdata,        32'h2000_0000);
      next_cyc(); no_fetch(); drive_resp(2, RDY_OK, 32'h2000_0004);
      mid_cyc(); check("t2_rdata1", imem_rdata, 32'h2000_0004);
      next_cyc(); drive_resp(2, RDY_OK, 32'h2000_0008);
      mid_cyc(); check("t2_rdata2", imem_rdata, 32'h2000_0008);
      next_cyc(); ports_idle();
      mid_cyc(); check("t2_idle", 32'(imem_resp), 32'(NOTRDY));

      // 3: target switch held until the outstanding port1 fetch returns
      next_cyc(); fetch(32'h0001_0010);
      mid_cyc(); check("t3_preq1", 32'(port_req), 32'h2);
      next_cyc(); fetch(32'h0003_0000);
      mid_cyc();
      check("t3_preq_held", 32'(port_req),     32'h0);
      check("t3_ack_held",  32'(imem_req_ack), 32'h0);
      next_cyc(); drive_resp(1, RDY_OK, 32'h1111_1111);
      mid_cyc();
      check("t3_preq3",  32'(port_req),     32'h8);
      check("t3_ack3",   32'(imem_req_ack), 32'h1);
      check("t3_rdata1", imem_rdata,        32'h1111_1111);
      next_cyc(); no_fetch(); drive_resp(3, RDY_OK, 32'h3333_3333);
      mid_cyc(); check("t3_rdata3", imem_rdata, 32'h3333_3333);
      next_cyc(); ports_idle();

      // 4: decode miss answered internally
      next_cyc(); fetch(32'h8000_0000); port_rdata = '1;
      mid_cyc();
      check("t4_ack",  32'(imem_req_ack), 32'h1);
      check("t4_preq", 32'(port_req),     32'h0);
      next_cyc(); no_fetch();
      mid_cyc();
      check("t4_resp",  32'(imem_resp), 32'(RDY_ER));
      check("t4_rdata", imem_rdata,     32'h0);
      check("t4_preq2", 32'(port_req),  32'h0);
      next_cyc(); ports_idle();
      mid_cyc(); check("t4_idle", 32'(imem_resp), 32'(NOTRDY));

      // 5: push+pop at full, then port RDY_ER followed by a younger RDY_OK
      next_cyc(); fetch(32'h0000_0100);
      mid_cyc(); check("t5_ack0", 32'(imem_req_ack), 32'h1);
      next_cyc(); fetch(32'h0000_0104);
      mid_cyc(); check("t5_ack1", 32'(imem_req_ack), 32'h1);
      next_cyc(); fetch(32'h0000_0108); drive_resp(0, RDY_OK, 32'hAAAA_0000);
      mid_cyc();
      check("t5_ack_full", 32'(imem_req_ack), 32'h1);
      check("t5_rdata0",   imem_rdata,        32'hAAAA_0000);
      next_cyc(); no_fetch(); drive_resp(0, RDY_ER, 32'h0);
      mid_cyc(); check("t5_resp_er", 32'(imem_resp), 32'(RDY_ER));
      next_cyc(); drive_resp(0, RDY_OK, 32'hAAAA_0008);
      mid_cyc();
      check("t5_resp2",  32'(imem_resp), 32'(RDY_OK));
      check("t5_rdata2", imem_rdata,     32'hAAAA_0008);
      next_cyc(); ports_idle();
      mid_cyc(); check("t5_idle", 32'(imem_resp), 32'(NOTRDY));

      // 6: async reset with two outstanding port1 fetches
      next_cyc(); fetch(32'h0001_0000);
      next_cyc(); fetch(32'h0001_0004);
      next_cyc(); fetch(32'h0001_0008); drive_resp(1, RDY_OK, 32'h5555_5555);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_ack",   32'(imem_req_ack), 32'h0);
      check("t6_rst_preq",  32'(port_req),     32'h0);
      check("t6_rst_resp",  32'(imem_resp),    32'(NOTRDY));
      check("t6_rst_rdata", imem_rdata,        32'h0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      no_fetch();
      mid_cyc();
      check("t6_late_resp",  32'(imem_resp), 32'(NOTRDY));
      check("t6_late_rdata", imem_rdata,     32'h0);
      next_cyc(); ports_idle(); fetch(32'h0001_0020);
      mid_cyc();
      check("t6_preq", 32'(port_req),     32'h2);
      check("t6_ack",  32'(imem_req_ack), 32'h1);
      next_cyc(); no_fetch(); drive_resp(1, RDY_OK, 32'hCAFE_F00D);
      mid_cyc();
      check("t6_resp",  32'(imem_resp), 32'(RDY_OK));
      check("t6_rdata", imem_rdata,     32'hCAFE_F00D);
      next_cyc(); ports_idle();
      mid_cyc(); check("t6_idle", 32'(imem_resp), 32'(NOTRDY));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
